// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Pipeline fetch stage. One outstanding imem read at a time, skid
//            slot for a stalled ID stage, redirect with wrong-path discard.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;

    logic        w_xfer;
    logic        w_slot_free;
    logic [1:0]  w_unused_lsb;

    assign imem_req        = (r_state == S_FETCH) && !rst;
    assign imem_addr       = r_pc;
    assign w_xfer          = imem_req && imem_ready;
    assign w_slot_free     = !r_valid || !stall;
    assign w_unused_lsb    = redirect_pc[1:0];
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign valid_out       = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_instr      <= 32'd0;
            r_pc_out     <= 32'd0;
            r_valid      <= 1'b0;
        end else begin
            // A delivery completes on valid && !stall; a new load below overrides this.
            if (r_valid && !stall) begin
                r_valid <= 1'b0;
            end

            if (redirect) begin
                r_pc         <= {redirect_pc[31:2], 2'b00};
                r_valid      <= 1'b0;
                r_skid_instr <= 32'd0;
                r_skid_pc    <= 32'd0;
                case (r_state)
                    S_FETCH: r_state <= w_xfer ? S_DRAIN : S_FETCH;
                    S_WAIT:  r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
                    S_HOLD:  r_state <= S_FETCH;
                    // A response landing now retires the stale request.
                    S_DRAIN: r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
                    default: r_state <= S_FETCH;
                endcase
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_xfer) begin
                            r_req_pc <= r_pc;
                            r_pc     <= r_pc + c_pc_step;
                            r_state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (w_slot_free) begin
                                r_instr  <= imem_rdata;
                                r_pc_out <= r_req_pc;
                                r_valid  <= 1'b1;
                                r_state  <= S_FETCH;
                            end else begin
                                r_skid_instr <= imem_rdata;
                                r_skid_pc    <= r_req_pc;
                                r_state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            r_instr  <= r_skid_instr;
                            r_pc_out <= r_skid_pc;
                            r_valid  <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_rvalid) begin
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_FETCH;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
